// File: rtl/soda_change_dispenser_if.sv
// Request/status bundle between the coin-accounting block (master) and the
// change/soda actuator sequencer (slave).
interface soda_change_dispenser_if;
  logic       req;
  logic       vend;
  logic [1:0] nickel_num;
  logic [1:0] dimes_num;
  logic       nickel_empty;
  logic       dime_empty;
  logic       busy;
  logic       done;
  logic       vend_sol;
  logic       dime_sol;
  logic       nickel_sol;
  logic [5:0] short_cents;
  logic       short_flag;

  modport master (
    output req, vend, nickel_num, dimes_num, nickel_empty, dime_empty,
    input  busy, done, vend_sol, dime_sol, nickel_sol, short_cents, short_flag
  );

  modport slave (
    input  req, vend, nickel_num, dimes_num, nickel_empty, dime_empty,
    output busy, done, vend_sol, dime_sol, nickel_sol, short_cents, short_flag
  );
endinterface

// File: rtl/soda_change_dispenser.sv
// Actuator sequencer: takes one vend/refund request and fires the soda,
// dime and nickel solenoids one item at a time with timed pulses and gaps.
// Items that cannot be paid because a hopper is empty are tallied in
// short_cents instead of being pulsed.
module soda_change_dispenser #(
  parameter int PULSE_CYCLES = 2500000,
  parameter int GAP_CYCLES   = 1250000,
  parameter int TIMER_W      = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  soda_change_dispenser_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    VEND_ON,
    DIME_ON,
    NICKEL_ON,
    GAP,
    DONE
  } state_t;

  localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYCLES);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES);

  state_t               state, state_nx;
  logic                 vend_pend, vend_pend_nx;
  logic [1:0]           dimes_pend, dimes_pend_nx;
  logic [1:0]           nickels_pend, nickels_pend_nx;
  logic [5:0]           short_q, short_nx;
  logic [TIMER_W-1:0]   timer, timer_nx;
  logic                 vend_sol_q, dime_sol_q, nickel_sol_q;

  // Next-state and datapath decisions; one item is resolved per SEL cycle.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned and infers a latch.
    state_nx        = state;
    vend_pend_nx    = vend_pend;
    dimes_pend_nx   = dimes_pend;
    nickels_pend_nx = nickels_pend;
    short_nx        = short_q;
    timer_nx        = timer;

    case (state)
      IDLE: begin
        if (bus.req) begin
          vend_pend_nx    = bus.vend;
          dimes_pend_nx   = bus.dimes_num;
          nickels_pend_nx = bus.nickel_num;
          short_nx        = '0;
          state_nx        = SEL;
        end
      end

      SEL: begin
        if (vend_pend) begin
          vend_pend_nx = 1'b0;
          timer_nx     = PULSE_LOAD;
          state_nx     = VEND_ON;
        end else if (dimes_pend != 2'd0) begin
          dimes_pend_nx = dimes_pend - 2'd1;
          if (bus.dime_empty) begin
            short_nx = short_q + 6'd10;
          end else begin
            timer_nx = PULSE_LOAD;
            state_nx = DIME_ON;
          end
        end else if (nickels_pend != 2'd0) begin
          nickels_pend_nx = nickels_pend - 2'd1;
          if (bus.nickel_empty) begin
            short_nx = short_q + 6'd5;
          end else begin
            timer_nx = PULSE_LOAD;
            state_nx = NICKEL_ON;
          end
        end else begin
          state_nx = DONE;
        end
      end

      VEND_ON, DIME_ON, NICKEL_ON: begin
        if (timer <= TIMER_W'(1)) begin
          timer_nx = GAP_LOAD;
          state_nx = GAP;
        end else begin
          timer_nx = timer - TIMER_W'(1);
        end
      end

      GAP: begin
        if (timer <= TIMER_W'(1)) begin
          state_nx = SEL;
        end else begin
          timer_nx = timer - TIMER_W'(1);
        end
      end

      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, pending counts, shortfall tally and timer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      vend_pend    <= 1'b0;
      dimes_pend   <= '0;
      nickels_pend <= '0;
      short_q      <= '0;
      timer        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state        <= state_nx;
      vend_pend    <= vend_pend_nx;
      dimes_pend   <= dimes_pend_nx;
      nickels_pend <= nickels_pend_nx;
      short_q      <= short_nx;
      timer        <= timer_nx;
    end
  end

  // Solenoid drivers registered from the upcoming state so each coil is
  // glitch-free, high exactly while its *_ON state is current, and dropped
  // asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vend_sol_q   <= 1'b0;
      dime_sol_q   <= 1'b0;
      nickel_sol_q <= 1'b0;
    end else begin
      vend_sol_q   <= (state_nx == VEND_ON);
      dime_sol_q   <= (state_nx == DIME_ON);
      nickel_sol_q <= (state_nx == NICKEL_ON);
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.vend_sol    = vend_sol_q;
  assign bus.dime_sol    = dime_sol_q;
  assign bus.nickel_sol  = nickel_sol_q;
  assign bus.short_cents = short_q;
  assign bus.short_flag  = (short_q != 6'd0);

endmodule

// File: tb/tb_soda_change_dispenser.sv
// Self-checking bench: directed cases from the timing description plus
// randomized requests, compared cycle by cycle against a timeline model that
// lists what each cycle of a request should look like.
module tb_soda_change_dispenser;

  localparam int P = 4;
  localparam int G = 2;

  logic clk;
  logic reset;

  soda_change_dispenser_if bus ();

  soda_change_dispenser #(
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G),
    .TIMER_W     (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected per-cycle view: {busy, done, vend_sol, dime_sol, nickel_sol, short[5:0]}
  typedef logic [10:0] obs_t;
  obs_t tl[$];
  int   prev_short = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic obs_t sample();
    return {bus.busy, bus.done, bus.vend_sol, bus.dime_sol, bus.nickel_sol, bus.short_cents};
  endfunction

  task automatic push(input int cnt, input bit b, input bit dn,
                      input bit vs, input bit ds, input bit ns, input int s);
    repeat (cnt) tl.push_back({b, dn, vs, ds, ns, 6'(s)});
  endtask

  // Timeline of a request starting at the cycle after acceptance. Hopper
  // levels are held constant for the whole request.
  task automatic build(input bit v, input int d, input int n,
                       input bit de, input bit ne, output int final_short);
    int s = 0;
    tl.delete();
    if (v) begin
      push(1, 1, 0, 0, 0, 0, s);
      push(P, 1, 0, 1, 0, 0, s);
      push(G, 1, 0, 0, 0, 0, s);
    end
    for (int i = 0; i < d; i++) begin
      push(1, 1, 0, 0, 0, 0, s);
      if (de) s += 10;
      else begin
        push(P, 1, 0, 0, 1, 0, s);
        push(G, 1, 0, 0, 0, 0, s);
      end
    end
    for (int i = 0; i < n; i++) begin
      push(1, 1, 0, 0, 0, 0, s);
      if (ne) s += 5;
      else begin
        push(P, 1, 0, 0, 0, 1, s);
        push(G, 1, 0, 0, 0, 0, s);
      end
    end
    push(1, 1, 0, 0, 0, 0, s);   // final SEL with nothing pending
    push(1, 1, 1, 0, 0, 0, s);   // DONE
    final_short = s;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle"}, 32'(sample()), 32'({5'b0, 6'(prev_short)}));
    check({tag, "_idle_flag"}, 32'(bus.short_flag), 32'(prev_short != 0));
  endtask

  // One request: optional idle cycles, accept on the next IDLE cycle, then
  // compare every busy cycle. Random req pulses and input churn while busy
  // must have no effect.
  task automatic run_req(input string tag, input bit v, input int d, input int n,
                         input bit de, input bit ne, input int idle_gap, input bit noise);
    int fs;
    repeat (idle_gap) begin
      @(negedge clk);
      bus.req = 1'b0;
      check_idle(tag);
    end
    @(negedge clk);
    check_idle(tag);
    bus.req          = 1'b1;
    bus.vend         = v;
    bus.dimes_num    = 2'(d);
    bus.nickel_num   = 2'(n);
    bus.dime_empty   = de;
    bus.nickel_empty = ne;
    build(v, d, n, de, ne, fs);
    for (int i = 0; i < tl.size(); i++) begin
      @(negedge clk);
      bus.req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        bus.vend       = 1'($urandom_range(0, 1));
        bus.dimes_num  = 2'($urandom_range(0, 3));
        bus.nickel_num = 2'($urandom_range(0, 3));
      end
      check($sformatf("%s_cyc%0d", tag, i + 1), 32'(sample()), 32'(tl[i]));
      check($sformatf("%s_flag%0d", tag, i + 1), 32'(bus.short_flag), 32'(tl[i][5:0] != 6'd0));
    end
    bus.req    = 1'b0;
    prev_short = fs;
  endtask

  initial begin
    bus.req          = 1'b0;
    bus.vend         = 1'b0;
    bus.dimes_num    = '0;
    bus.nickel_num   = '0;
    bus.dime_empty   = 1'b0;
    bus.nickel_empty = 1'b0;
    reset            = 1'b1;

    #3;
    check("reset_outputs", 32'(sample()), 32'd0);
    check("reset_flag", 32'(bus.short_flag), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed cases, back to back so each req lands on the first IDLE cycle.
    run_req("vend_only",   1, 0, 0, 0, 0, 1, 0);
    run_req("dimes_nick",  0, 2, 1, 0, 0, 0, 1);
    run_req("dime_empty",  0, 2, 1, 1, 0, 0, 0);
    run_req("empty_req",   0, 0, 0, 0, 0, 0, 1);   // also shows short_cents cleared
    run_req("all_short",   0, 3, 3, 1, 1, 0, 0);   // 45-cent maximum
    run_req("max_load",    1, 3, 3, 0, 0, 0, 1);

    // Reset in the middle of a dime pulse drops everything without a clk edge.
    @(negedge clk);
    bus.req = 1'b1; bus.vend = 1'b0; bus.dimes_num = 2'd2; bus.nickel_num = 2'd1;
    bus.dime_empty = 1'b0; bus.nickel_empty = 1'b0;
    @(negedge clk); bus.req = 1'b0;   // cycle 1, SEL
    @(negedge clk);                   // cycle 2
    @(negedge clk);                   // cycle 3, mid dime pulse
    check("pre_reset_dime_sol", 32'(bus.dime_sol), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'(sample()), 32'd0);
    @(negedge clk);
    reset      = 1'b0;
    prev_short = 0;
    run_req("post_reset", 1, 1, 0, 0, 0, 0, 0);

    // Randomized requests.
    for (int k = 0; k < 40; k++) begin
      run_req($sformatf("rnd%0d", k),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check_idle("final");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
